// File: rtl/door_pkg.sv
// Shared definitions for the door sequencing slice.
//   door_state_e : door FSM state encoding
//   DOOR_CNT_W   : width of the tick counter used by door timing
//   door_last_cnt: counter value on which a phase lasting 'ticks' door_clk
//                  rises ends
package door_pkg;

  localparam int DOOR_CNT_W = 8;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_state_e;

  function automatic logic [DOOR_CNT_W-1:0] door_last_cnt(input int unsigned ticks);
    return DOOR_CNT_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/door_if.sv
// Request/status bundle between the move/floor controller and the door
// sequencer.
//   Requests (controller -> sequencer): open_req, open_btn, close_btn,
//     weight_limit_exceeded.
//   Status (sequencer -> controller): door_closed, door_open, door_moving,
//     move_enable.
// Signalling: every signal is a plain level with no valid/ready pairing.
// Requests are sampled on every clk edge for as long as they are high;
// status outputs are registered and change only on clk edges (or async
// reset). The controller is expected to drop open_req once door_open is seen.
interface door_if;

  logic open_req;
  logic open_btn;
  logic close_btn;
  logic weight_limit_exceeded;
  logic door_closed;
  logic door_open;
  logic door_moving;
  logic move_enable;

  modport master (
    output open_req, open_btn, close_btn, weight_limit_exceeded,
    input  door_closed, door_open, door_moving, move_enable
  );

  modport slave (
    input  open_req, open_btn, close_btn, weight_limit_exceeded,
    output door_closed, door_open, door_moving, move_enable
  );

endinterface

// File: rtl/door_tick_detect.sv
// Rising-edge detector for the slow door_clk timing signal.
//   clk, rst_n : system clock, async active-low reset
//   sig_i      : door_clk (same clock domain)
//   tick_o     : one-clk pulse per rising edge of sig_i; falling edges ignored
module door_tick_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic tick_o
);

  logic door_clk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door_clk_q <= 1'b0;
    end else begin
      door_clk_q <= sig_i;
    end
  end

  assign tick_o = sig_i & ~door_clk_q;

endmodule

// File: rtl/door_sequencer.sv
// Door sequencer: drives the door through closed -> opening -> open (dwell)
// -> closing, holding it open under overload and reporting when the car may
// move.
//   clk, rst_n : system clock, async active-low reset
//   door_clk   : slow door timing signal; its rising edges pace the door
//   bus        : request inputs and registered status outputs (door_if.slave)
//   state_o    : current FSM state, for observation
module door_sequencer
  import door_pkg::*;
#(
  parameter int unsigned OPEN_TICKS = 3,
  parameter int unsigned MOVE_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        door_clk,
  door_if.slave       bus,
  output door_state_e state_o
);

  localparam logic [DOOR_CNT_W-1:0] OPEN_LAST = door_last_cnt(OPEN_TICKS);
  localparam logic [DOOR_CNT_W-1:0] MOVE_LAST = door_last_cnt(MOVE_TICKS);

  door_state_e           state_q, state_d;
  logic [DOOR_CNT_W-1:0] cnt_q, cnt_d;
  logic                  tick;
  logic                  door_closed_q, door_open_q, door_moving_q, move_enable_q;

  door_tick_detect u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (door_clk),
    .tick_o (tick)
  );

  // cnt counts door_clk rises spent in the current state; every state change
  // clears it, so a tick that causes an entry is never counted in the new state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLOSED: begin
        if (bus.open_req || bus.open_btn) begin
          state_d = OPENING;
          cnt_d   = '0;
        end
      end
      OPENING: begin
        if (tick) begin
          if (cnt_q == MOVE_LAST) begin
            state_d = OPEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OPEN: begin
        // Overload or a held open button restarts the dwell every cycle and
        // outranks both close_btn and dwell expiry.
        if (bus.weight_limit_exceeded || bus.open_btn) begin
          cnt_d = '0;
        end else if (bus.close_btn) begin
          state_d = CLOSING;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == OPEN_LAST) begin
            state_d = CLOSING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CLOSING: begin
        // Reversal is checked before tick processing.
        if (bus.weight_limit_exceeded || bus.open_btn || bus.open_req) begin
          state_d = OPENING;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == MOVE_LAST) begin
            state_d = CLOSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = CLOSED;
        cnt_d   = '0;
      end
    endcase
  end

  // Status is decoded from the next state so a transition taken on an edge
  // is visible right after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLOSED;
      cnt_q         <= '0;
      door_closed_q <= 1'b1;
      door_open_q   <= 1'b0;
      door_moving_q <= 1'b0;
      move_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      door_closed_q <= (state_d == CLOSED);
      door_open_q   <= (state_d == OPEN);
      door_moving_q <= (state_d == OPENING) || (state_d == CLOSING);
      move_enable_q <= (state_d == CLOSED) && !bus.open_req && !bus.open_btn
                       && !bus.weight_limit_exceeded;
    end
  end

  assign bus.door_closed = door_closed_q;
  assign bus.door_open   = door_open_q;
  assign bus.door_moving = door_moving_q;
  assign bus.move_enable = move_enable_q;
  assign state_o         = state_q;

endmodule
